datapath_result_packer: RTL and testbench
=========================================

Name: datapath_result_packer

Overview:
- Downstream consumer of the 16-bit pipeline datapath output.
- Captures qualified result samples and packs consecutive pairs into 32-bit words.
- Buffers the packed words in a small first-word-fall-through FIFO and presents them on a valid/ready interface to the result sink.
- Flags and counts any words lost because the sink stalled too long.

Parameters:
DATA_W, 16, width of one datapath result sample
FIFO_DEPTH, 4, packed-word FIFO entries; power of two, >= 2

Ports:
clk  input  1  single clock, rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  in_data carries a valid datapath result this cycle
in_data  input  DATA_W  datapath result sample
flush  input  1  force out any half-packed sample
out_valid  output  1  FIFO head holds a word
out_ready  input  1  sink accepts the head word
out_data  output  2*DATA_W  packed word {second sample, first sample}
out_partial  output  1  head word is a flushed single sample (upper half zero)
fifo_level  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
overflow  output  1  sticky; set when a packed word was dropped
drop_count  output  8  dropped-word count, saturates at 255

Behaviour:
- Reset: clk is the only clock; rst is synchronous and active-high. On reset:
  - out_valid=0, out_data=0, out_partial=0, fifo_level=0, overflow=0, drop_count=0.
  - Pack state returns to EMPTY and the holding register clears.
  - All of this takes effect on the first clk edge with rst=1 and applies mid-operation: held half-words and FIFO contents are discarded.
- Pack FSM:
  - EMPTY, in_valid, !flush: hold in_data, go to HALF.
  - EMPTY, in_valid, flush: push {0, in_data} with partial=1, stay EMPTY.
  - EMPTY, !in_valid: no action; flush is ignored.
  - HALF, in_valid: push {in_data, held} with partial=0, go to EMPTY. This holds with or without flush.
  - HALF, !in_valid, flush: push {0, held} with partial=1, go to EMPTY.
  - HALF, !in_valid, !flush: hold.
- FIFO:
  - Write is registered. Output is first-word-fall-through from storage.
  - A word pushed at edge N is visible with out_valid=1 after edge N, i.e. one cycle after the completing sample is presented.
  - out_valid = (level != 0). Pop occurs when out_valid && out_ready.
  - out_data and out_partial stay stable while out_valid && !out_ready.
  - Order is strictly FIFO. Pointers wrap modulo FIFO_DEPTH.
- Full and drop rules:
  - Push with level==FIFO_DEPTH and no pop in the same cycle: the word is dropped, overflow is set, and drop_count increments, saturating at 255.
  - The pack FSM still advances on a drop, so samples are lost, not stalled. No backpressure is applied to the datapath.
  - Push and pop in the same cycle while full: both succeed, no drop, level is unchanged.
  - Push and pop in the same cycle while empty: impossible, because out_valid=0.
- overflow and drop_count clear only on rst.
- fifo_level updates each edge: +1 on a push-only cycle, -1 on a pop-only cycle, unchanged when both or neither occur.

Optional Feature:
- Macro: PACKER_PARITY_EN.
- Defined:
  - Adds output port out_parity (1 bit), the even-parity bit (XOR reduction) of out_data for the head entry.
  - Parity is computed at push time and stored per FIFO entry.
  - Reset value is 0. out_parity is stable under the same rules as out_data.
- Undefined: the port, its storage and its logic are absent. All other behaviour is identical.

Test Plan:
- Reset then idle 5 cycles -> out_valid=0, fifo_level=0, overflow=0, drop_count=0, out_data=0.
- out_ready=1; in_data 0x000A then 0x0014 on consecutive cycles with in_valid=1 -> one cycle after the second sample, out_valid=1, out_data=0x0014000A, out_partial=0; popped next edge, level returns to 0.
- in_valid with 0x001E, next cycle flush=1 and in_valid=0 -> out_data=0x0000001E, out_partial=1; a following pair 0x0028,0x0032 gives 0x00320028.
- out_ready=0; 10 samples 0x0001..0x000A -> level=4, overflow=1, drop_count=1; then out_ready=1 drains 0x00020001, 0x00040003, 0x00060005, 0x00080007 in order; 0x000A0009 is absent.
- FIFO full, out_ready=1, pair completing the same cycle -> no drop, level stays 4, drop_count unchanged.
- Mid-HALF with level=2, assert rst for 1 cycle -> next cycle everything is zero; the subsequent pair 0x1111,0x2222 yields 0x22221111, so the old half is discarded.

Source files
------------

// File: rtl/datapath_result_packer_if.sv
// Bus bundle for datapath_result_packer: sample input side and packed-word output side.
// PACKER_PARITY_EN adds out_parity to the bundle.
`timescale 1ns/1ps
interface datapath_result_packer_if #(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned FIFO_DEPTH = 4
);
    logic                          in_valid;
    logic [DATA_W-1:0]             in_data;
    logic                          flush;
    logic                          out_valid;
    logic                          out_ready;
    logic [2*DATA_W-1:0]           out_data;
    logic                          out_partial;
    logic [$clog2(FIFO_DEPTH):0]   fifo_level;
    logic                          overflow;
    logic [7:0]                    drop_count;
`ifdef PACKER_PARITY_EN
    logic                          out_parity;

    modport master (
        output in_valid, in_data, flush, out_ready,
        input  out_valid, out_data, out_partial, fifo_level, overflow, drop_count, out_parity
    );
    modport slave (
        input  in_valid, in_data, flush, out_ready,
        output out_valid, out_data, out_partial, fifo_level, overflow, drop_count, out_parity
    );
`else
    modport master (
        output in_valid, in_data, flush, out_ready,
        input  out_valid, out_data, out_partial, fifo_level, overflow, drop_count
    );
    modport slave (
        input  in_valid, in_data, flush, out_ready,
        output out_valid, out_data, out_partial, fifo_level, overflow, drop_count
    );
`endif
endinterface

// File: rtl/datapath_result_packer.sv
// Packs pairs of datapath samples into words, buffers them in a FWFT FIFO, counts drops.
// Define PACKER_PARITY_EN to store and present a per-entry even-parity bit (out_parity).
`timescale 1ns/1ps
module datapath_result_packer #(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    datapath_result_packer_if.slave bus
);
    localparam int unsigned AW      = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_L = (AW+1)'(FIFO_DEPTH);

    typedef enum logic {ST_EMPTY, ST_HALF} state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [DATA_W-1:0]   r_hold;
    logic                w_push;
    logic                w_push_partial;
    logic [2*DATA_W-1:0] w_push_data;

    logic [2*DATA_W-1:0] r_mem_data [FIFO_DEPTH];
    logic                r_mem_part [FIFO_DEPTH];
    logic [AW-1:0]       r_wptr;
    logic [AW-1:0]       r_rptr;
    logic [AW:0]         r_level;
    logic                r_overflow;
    logic [7:0]          r_drop_cnt;

    logic w_valid;
    logic w_pop;
    logic w_full;
    logic w_wr;
    logic w_drop;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_EMPTY;
            r_hold  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_EMPTY && bus.in_valid && !bus.flush)
                r_hold <= bus.in_data;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_push         = 1'b0;
        w_push_partial = 1'b0;
        w_push_data    = '0;
        case (r_state)
            ST_EMPTY: begin
                if (bus.in_valid) begin
                    if (bus.flush) begin
                        w_push         = 1'b1;
                        w_push_partial = 1'b1;
                        w_push_data    = {{DATA_W{1'b0}}, bus.in_data};
                    end else begin
                        w_state_nxt = ST_HALF;
                    end
                end
            end
            ST_HALF: begin
                if (bus.in_valid) begin
                    w_push      = 1'b1;
                    w_push_data = {bus.in_data, r_hold};
                    w_state_nxt = ST_EMPTY;
                end else if (bus.flush) begin
                    w_push         = 1'b1;
                    w_push_partial = 1'b1;
                    w_push_data    = {{DATA_W{1'b0}}, r_hold};
                    w_state_nxt    = ST_EMPTY;
                end
            end
            default: w_state_nxt = ST_EMPTY;
        endcase
    end

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign w_valid = (r_level != '0);
    assign w_pop   = w_valid && bus.out_ready;
    assign w_full  = (r_level == DEPTH_L);
    assign w_wr    = w_push && (!w_full || w_pop);
    assign w_drop  = w_push && w_full && !w_pop;

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem_data[r_wptr] <= w_push_data;
            r_mem_part[r_wptr] <= w_push_partial;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end else begin
            if (w_wr)
                r_wptr <= r_wptr + AW'(1);
            if (w_pop)
                r_rptr <= r_rptr + AW'(1);
            case ({w_wr, w_pop})
                2'b10:   r_level <= r_level + (AW+1)'(1);
                2'b01:   r_level <= r_level - (AW+1)'(1);
                default: r_level <= r_level;
            endcase
            if (w_drop) begin
                r_overflow <= 1'b1;
                if (r_drop_cnt != 8'hFF)
                    r_drop_cnt <= r_drop_cnt + 8'd1;
            end
        end
    end

    assign bus.out_valid   = w_valid;
    assign bus.out_data    = w_valid ? r_mem_data[r_rptr] : '0;
    assign bus.out_partial = w_valid ? r_mem_part[r_rptr] : 1'b0;
    assign bus.fifo_level  = r_level;
    assign bus.overflow    = r_overflow;
    assign bus.drop_count  = r_drop_cnt;

`ifdef PACKER_PARITY_EN
    logic r_mem_par [FIFO_DEPTH];

    always_ff @(posedge clk) begin
        if (w_wr)
            r_mem_par[r_wptr] <= ^w_push_data;
    end

    assign bus.out_parity = w_valid ? r_mem_par[r_rptr] : 1'b0;
`endif

endmodule

// File: tb/tb_datapath_result_packer.sv
// Scoreboard bench for datapath_result_packer: directed scenarios then randomized traffic
// against a sample-queue reference model.
`timescale 1ns/1ps
module tb_datapath_result_packer;
    localparam int unsigned DW    = 16;
    localparam int unsigned DEPTH = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    datapath_result_packer_if #(.DATA_W(DW), .FIFO_DEPTH(DEPTH)) bus ();

    datapath_result_packer #(.DATA_W(DW), .FIFO_DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [31:0] d;
        logic        p;
    } word_t;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [15:0] pend[$];
    word_t       sb[$];
    int          m_level = 0;
    bit          m_ovf   = 1'b0;
    int          m_drops = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: samples queue up; two make a word, a flush turns a lone sample into a partial word.
    task automatic model_step();
        bit    pop;
        bit    have;
        word_t w;
        if (rst) begin
            pend.delete();
            sb.delete();
            m_level = 0;
            m_ovf   = 1'b0;
            m_drops = 0;
            return;
        end
        pop  = (m_level > 0) && bus.out_ready;
        have = 1'b0;
        w.d  = '0;
        w.p  = 1'b0;
        if (bus.in_valid)
            pend.push_back(bus.in_data);
        if (pend.size() == 2) begin
            w.d  = {pend[1], pend[0]};
            w.p  = 1'b0;
            have = 1'b1;
            pend.delete();
        end else if (bus.flush && pend.size() == 1) begin
            w.d  = {16'h0000, pend[0]};
            w.p  = 1'b1;
            have = 1'b1;
            pend.delete();
        end
        if (have) begin
            if (m_level == DEPTH && !pop) begin
                m_ovf = 1'b1;
                if (m_drops < 255) m_drops++;
            end else begin
                sb.push_back(w);
                m_level++;
            end
        end
        if (pop) m_level--;
    endtask

    task automatic status_check();
        check("out_valid",  32'(bus.out_valid),  32'(m_level != 0));
        check("fifo_level", 32'(bus.fifo_level), 32'(m_level));
        check("overflow",   32'(bus.overflow),   32'(m_ovf));
        check("drop_count", 32'(bus.drop_count), 32'(m_drops));
    endtask

    task automatic cyc(input bit v, input logic [15:0] d, input bit f, input bit r, input bit rs);
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.flush     = f;
        bus.out_ready = r;
        rst           = rs;
        @(posedge clk);
        #1;
        model_step();
        status_check();
    endtask

    // Monitor: compares the presented head word against the scoreboard head; pops on handshake.
    always @(negedge clk) begin
        if (!rst && bus.out_valid) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL sb_empty: got word %h expected no word at %0t", bus.out_data, $time);
            end else begin
                check("out_data",    bus.out_data,          sb[0].d);
                check("out_partial", 32'(bus.out_partial),  32'(sb[0].p));
`ifdef PACKER_PARITY_EN
                check("out_parity",  32'(bus.out_parity),   32'(^sb[0].d));
`endif
                if (bus.out_ready) void'(sb.pop_front());
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        rst           = 1'b1;

        cyc(0, 16'h0, 0, 0, 1);
        cyc(0, 16'h0, 0, 0, 1);
        for (int i = 0; i < 5; i++) cyc(0, 16'h0, 0, 0, 0);
        check("reset_out_data",    bus.out_data,          32'h0);
        check("reset_out_partial", 32'(bus.out_partial),  32'h0);

        // Basic pair with sink ready
        cyc(1, 16'h000A, 0, 1, 0);
        cyc(1, 16'h0014, 0, 1, 0);
        check("pair_data", bus.out_data, 32'h0014000A);
        check("pair_part", 32'(bus.out_partial), 32'h0);
        cyc(0, 16'h0, 0, 1, 0);
        check("pair_drained", 32'(bus.fifo_level), 32'h0);

        // Flushed half, then a normal pair
        cyc(1, 16'h001E, 0, 1, 0);
        cyc(0, 16'h0, 1, 1, 0);
        check("flush_data", bus.out_data, 32'h0000001E);
        check("flush_part", 32'(bus.out_partial), 32'h1);
        cyc(1, 16'h0028, 0, 1, 0);
        cyc(1, 16'h0032, 0, 1, 0);
        check("pair2_data", bus.out_data, 32'h00320028);
        cyc(0, 16'h0, 0, 1, 0);
        cyc(0, 16'h0, 1, 1, 0);

        // Overflow: ten samples into a stalled sink
        for (int i = 1; i <= 10; i++) cyc(1, 16'(i), 0, 0, 0);
        check("ovf_level", 32'(bus.fifo_level), 32'd4);
        check("ovf_flag",  32'(bus.overflow),   32'd1);
        check("ovf_drops", 32'(bus.drop_count), 32'd1);
        check("ovf_head",  bus.out_data,        32'h00020001);
        for (int i = 0; i < 6; i++) cyc(0, 16'h0, 0, 1, 0);

        // Full FIFO, push and pop in the same cycle
        for (int i = 0; i < 9; i++) cyc(1, 16'(16'h0100 + i), 0, 0, 0);
        check("full_level", 32'(bus.fifo_level), 32'd4);
        cyc(1, 16'h0200, 0, 1, 0);
        check("pushpop_level", 32'(bus.fifo_level), 32'd4);
        check("pushpop_drops", 32'(bus.drop_count), 32'd1);
        for (int i = 0; i < 6; i++) cyc(0, 16'h0, 0, 1, 0);

        // Reset mid-HALF with two words queued
        for (int i = 0; i < 5; i++) cyc(1, 16'(16'h0300 + i), 0, 0, 0);
        check("pre_rst_level", 32'(bus.fifo_level), 32'd2);
        cyc(0, 16'h0, 0, 0, 1);
        check("post_rst_data",  bus.out_data,          32'h0);
        check("post_rst_drops", 32'(bus.drop_count),   32'h0);
        cyc(1, 16'h1111, 0, 1, 0);
        cyc(1, 16'h2222, 0, 1, 0);
        check("post_rst_pair", bus.out_data, 32'h22221111);
        cyc(0, 16'h0, 0, 1, 0);

        // Drop counter saturation
        for (int i = 0; i < 600; i++) cyc(1, 16'($urandom), 0, 0, 0);
        check("sat_drops", 32'(bus.drop_count), 32'd255);
        for (int i = 0; i < 6; i++) cyc(0, 16'h0, 0, 1, 0);
        cyc(0, 16'h0, 0, 0, 1);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 99) < 70),
                16'($urandom),
                ($urandom_range(0, 99) < 15),
                ($urandom_range(0, 99) < 60),
                ($urandom_range(0, 199) == 0));
        end
        for (int i = 0; i < 8; i++) cyc(0, 16'h0, 1, 1, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
